// File: rtl/jtag_types_pkg.sv
// Shared types and constants for the AHB-Lite debug access point.
//   ap_op_t     : 3-bit debug command opcodes
//   ap_state_t  : access-point FSM states
//   htrans_t    : AHB HTRANS encoding (only IDLE and NONSEQ are used)
//   decode_op() : extracts the opcode from the top bits of a command word
package jtag_types_pkg;

    typedef enum logic [2:0] {
        OpNop     = 3'd0,
        OpSetAddr = 3'd1,
        OpWrite   = 3'd2,
        OpRead    = 3'd3,
        OpReadN   = 3'd4,
        OpSetCsr  = 3'd5,
        OpClrErr  = 3'd6,
        OpRsvd    = 3'd7
    } ap_op_t;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StAddr,
        StData,
        StRsp
    } ap_state_t;

    typedef logic [1:0] htrans_t;

    localparam htrans_t     HTRANS_IDLE   = 2'b00;
    localparam htrans_t     HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0]  HBURST_SINGLE = 3'b000;
    localparam logic [31:0] AP_ERR_WORD   = 32'hDEAD_BEEF;

    function automatic ap_op_t decode_op(input logic [2:0] op_bits);
        return ap_op_t'(op_bits);
    endfunction

endpackage

// File: rtl/ahb_ap_master.sv
// AHB-Lite master access point. Pops debug commands from a first-word-fall-through
// command FIFO, runs each as a single non-pipelined AHB-Lite transfer and pushes read
// data into a response FIFO. Holds an address register with optional auto-increment
// and supports multi-word reads (READ_N).
//
// Command word: {op[2:0], size[1:0], payload[DATA_W-1:0]}
//
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   rempty, rdata, rinc  command FIFO: empty flag, head word, pop strobe
//   wfull, wdata, winc   response FIFO: full flag, push word, push strobe
//   HADDR..HWDATA        AHB-Lite master outputs (single NONSEQ transfers only)
//   HRDATA,HREADY,HRESP  AHB-Lite slave responses
//   busy                 high whenever the FSM is not idle
//   err                  sticky bus error
//
// Build option: define AHB_AP_ERR_EN to honour HRESP. Without it HRESP is ignored,
// err is tied 0 and CLR_ERR is a no-op.
module ahb_ap_master
    import jtag_types_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned CMD_W  = DATA_W + 5
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              rempty,
    input  logic [CMD_W-1:0]  rdata,
    output logic              rinc,
    input  logic              wfull,
    output logic [DATA_W-1:0] wdata,
    output logic              winc,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP,
    output logic              busy,
    output logic              err
);

    ap_state_t         state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              autoinc_q;
    logic [ADDR_W-1:0] haddr_q;
    htrans_t           htrans_q;
    logic              hwrite_q;
    logic [1:0]        size_q;
    logic [DATA_W-1:0] hwdata_q;
    logic [DATA_W-1:0] rsp_q;
    logic [CNT_W-1:0]  cnt_q;  // beats still to run after the current one

    // Command fields straight off the FIFO head
    ap_op_t            cmd_op;
    logic [1:0]        cmd_size;
    logic [DATA_W-1:0] cmd_payload;
    logic [CNT_W-1:0]  cmd_cnt;
    logic [CNT_W-1:0]  cmd_extra_beats;
    logic [ADDR_W-1:0] addr_step;
    logic              xfer_fault;
    logic              cmd_blocked;

    assign cmd_op      = decode_op(rdata[DATA_W+2 +: 3]);
    assign cmd_size    = rdata[DATA_W +: 2];
    assign cmd_payload = rdata[DATA_W-1:0];
    assign cmd_cnt     = cmd_payload[CNT_W-1:0];
    // A count of zero still runs one beat
    assign cmd_extra_beats = (cmd_cnt == '0) ? '0 : cmd_cnt - CNT_W'(1);
    assign addr_step       = ADDR_W'(1) << size_q;

`ifdef AHB_AP_ERR_EN
    localparam logic [DATA_W-1:0] ErrWord = DATA_W'(AP_ERR_WORD);
    logic err_q;
    // err_q can only be set during this transfer's data phase: no transfer starts
    // while it is set, so it also remembers an HRESP seen in an earlier wait cycle.
    assign xfer_fault  = HRESP | err_q;
    assign cmd_blocked = err_q && (cmd_op != OpClrErr);
    assign err         = err_q;
`else
    logic unused_hresp;
    assign unused_hresp = HRESP;
    assign xfer_fault   = 1'b0;
    assign cmd_blocked  = 1'b0;
    assign err          = 1'b0;
`endif

    // Strobes decode the state register; winc must also see wfull this cycle so it
    // can never push into a full FIFO.
    assign rinc   = (state_q == StFetch);
    assign winc   = (state_q == StRsp) && !wfull;
    assign busy   = (state_q != StIdle);
    assign wdata  = rsp_q;
    assign HADDR  = haddr_q;
    assign HTRANS = htrans_q;
    assign HWRITE = hwrite_q;
    assign HSIZE  = {1'b0, size_q};
    assign HBURST = HBURST_SINGLE;
    assign HWDATA = hwdata_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            autoinc_q <= 1'b0;
            haddr_q   <= '0;
            htrans_q  <= HTRANS_IDLE;
            hwrite_q  <= 1'b0;
            size_q    <= 2'b00;
            hwdata_q  <= '0;
            rsp_q     <= '0;
            cnt_q     <= '0;
`ifdef AHB_AP_ERR_EN
            err_q     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!rempty) state_q <= StFetch;
                end

                StFetch: begin
                    state_q <= StIdle;
                    if (!cmd_blocked) begin
                        unique case (cmd_op)
                            OpSetAddr: addr_q    <= ADDR_W'(cmd_payload);
                            OpSetCsr:  autoinc_q <= cmd_payload[0];
                            OpClrErr: begin
`ifdef AHB_AP_ERR_EN
                                err_q <= 1'b0;
`endif
                            end
                            OpWrite, OpRead, OpReadN: begin
                                state_q  <= StAddr;
                                htrans_q <= HTRANS_NONSEQ;
                                haddr_q  <= addr_q;
                                hwrite_q <= (cmd_op == OpWrite);
                                size_q   <= cmd_size;
                                hwdata_q <= cmd_payload;
                                cnt_q    <= (cmd_op == OpReadN) ? cmd_extra_beats : '0;
                            end
                            default: ;  // NOP and reserved opcode: popped only
                        endcase
                    end
                end

                StAddr: begin
                    htrans_q <= HTRANS_IDLE;
                    state_q  <= StData;
                end

                StData: begin
`ifdef AHB_AP_ERR_EN
                    if (HRESP) err_q <= 1'b1;
`endif
                    if (HREADY) begin
                        if (autoinc_q) addr_q <= addr_q + addr_step;
                        if (hwrite_q) begin
                            state_q <= StIdle;
                        end else begin
                            state_q <= StRsp;
`ifdef AHB_AP_ERR_EN
                            rsp_q <= xfer_fault ? ErrWord : HRDATA;
`else
                            rsp_q <= HRDATA;
`endif
                            // A faulted read abandons any remaining beats
                            if (xfer_fault) cnt_q <= '0;
                        end
                    end
                end

                StRsp: begin
                    if (!wfull) begin
                        if (cnt_q != '0) begin
                            cnt_q    <= cnt_q - CNT_W'(1);
                            haddr_q  <= addr_q;
                            htrans_q <= HTRANS_NONSEQ;
                            state_q  <= StAddr;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
